// File: rtl/intersection_ctrl.sv
// Two-road intersection controller: NS/EW signal heads, pedestrian walk
// phase granted during all-red clearance, and a night flashing mode.
// Everything runs on clk; phase timing uses an internal tick enable.
module intersection_ctrl #(
    parameter int F_CLK    = 50_000_000,
    parameter int F_TICK   = 1,
    parameter int T_GREEN  = 25,
    parameter int T_YELLOW = 5,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic [2:0] phase,
    output logic [3:0] remain_tens,
    output logic [3:0] remain_ones,
    output logic       tick_o
);

    localparam int DIV = F_CLK / F_TICK;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [2:0] S_NS_GREEN  = 3'd0;
    localparam logic [2:0] S_NS_YELLOW = 3'd1;
    localparam logic [2:0] S_ALLRED_A  = 3'd2;
    localparam logic [2:0] S_EW_GREEN  = 3'd3;
    localparam logic [2:0] S_EW_YELLOW = 3'd4;
    localparam logic [2:0] S_ALLRED_B  = 3'd5;
    localparam logic [2:0] S_NIGHT     = 3'd6;

    localparam logic [6:0] LD_GREEN  = 7'(T_GREEN);
    localparam logic [6:0] LD_YELLOW = 7'(T_YELLOW);
    localparam logic [6:0] LD_ALLRED = 7'(T_ALLRED);
    localparam logic [6:0] LD_PED    = 7'(T_PED);
    localparam logic [3:0] RST_TENS  = 4'(T_ALLRED / 10);
    localparam logic [3:0] RST_ONES  = 4'(T_ALLRED % 10);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state, state_n;
    logic [6:0]    remain, remain_n;
    logic          blink, blink_n;
    logic          walk_n;
    logic          grant;
    logic          enter_night;

    assign tick   = (tick_cnt == CNT_LAST);
    assign tick_o = tick;
    assign phase  = state;

    // Free-running tick divider: wraps to 0 on the tick cycle.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Next-state, remaining-time, blink and walk-grant decision.
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n     = state;
        remain_n    = remain;
        blink_n     = blink;
        walk_n      = ped_walk;
        grant       = 1'b0;
        enter_night = 1'b0;
        if (state > S_NIGHT) begin
            // Unused encoding: recover to the clearance phase right away.
            state_n  = S_ALLRED_B;
            remain_n = LD_ALLRED;
            blink_n  = 1'b0;
            walk_n   = 1'b0;
        end else if (tick) begin
            if (state == S_NIGHT) begin
                if (!night) begin
                    state_n  = S_ALLRED_B;
                    remain_n = LD_ALLRED;
                    blink_n  = 1'b0;
                end else begin
                    blink_n = ~blink;
                end
            end else if (remain > 7'd1) begin
                remain_n = remain - 7'd1;
            end else begin
                walk_n = 1'b0;
                case (state)
                    S_NS_GREEN: begin
                        state_n  = S_NS_YELLOW;
                        remain_n = LD_YELLOW;
                    end
                    S_NS_YELLOW, S_EW_YELLOW: begin
                        // Walk is granted only from a request latched before this edge.
                        state_n  = (state == S_NS_YELLOW) ? S_ALLRED_A : S_ALLRED_B;
                        grant    = ped_wait;
                        walk_n   = ped_wait;
                        remain_n = ped_wait ? LD_PED : LD_ALLRED;
                    end
                    S_ALLRED_A: begin
                        state_n  = S_EW_GREEN;
                        remain_n = LD_GREEN;
                    end
                    S_EW_GREEN: begin
                        state_n  = S_EW_YELLOW;
                        remain_n = LD_YELLOW;
                    end
                    S_ALLRED_B: begin
                        if (night) begin
                            state_n     = S_NIGHT;
                            remain_n    = 7'd0;
                            blink_n     = 1'b0;
                            enter_night = 1'b1;
                        end else begin
                            state_n  = S_NS_GREEN;
                            remain_n = LD_GREEN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Phase registers, pedestrian latch and walk output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_ALLRED_B;
            remain   <= LD_ALLRED;
            blink    <= 1'b0;
            ped_walk <= 1'b0;
            ped_wait <= 1'b0;
        end else begin
            state    <= state_n;
            remain   <= remain_n;
            blink    <= blink_n;
            ped_walk <= walk_n;
            // Night holds the latch clear; otherwise a new request beats a same-cycle grant.
            if (enter_night || state == S_NIGHT) ped_wait <= 1'b0;
            else if (ped_req)                    ped_wait <= 1'b1;
            else if (grant)                      ped_wait <= 1'b0;
        end
    end

    // BCD split of remaining ticks, one clk behind remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_tens <= RST_TENS;
            remain_ones <= RST_ONES;
        end else begin
            remain_tens <= 4'(remain / 7'd10);
            remain_ones <= 4'(remain % 7'd10);
        end
    end

    // Moore decode of the signal heads from state and blink.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        case (state)
            S_NS_GREEN:  ns_light = GREEN;
            S_NS_YELLOW: ns_light = YELLOW;
            S_EW_GREEN:  ew_light = GREEN;
            S_EW_YELLOW: ew_light = YELLOW;
            S_NIGHT: begin
                ns_light = {1'b0, blink, 1'b0};
                ew_light = {1'b0, blink, 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with DIV=10, T_GREEN=3, T_YELLOW=2,
// T_ALLRED=1, T_PED=4. Every phase is checked sample by sample on negedges.
module tb_intersection_ctrl;

    localparam logic [2:0] P_NSG = 3'd0;
    localparam logic [2:0] P_NSY = 3'd1;
    localparam logic [2:0] P_ARA = 3'd2;
    localparam logic [2:0] P_EWG = 3'd3;
    localparam logic [2:0] P_EWY = 3'd4;
    localparam logic [2:0] P_ARB = 3'd5;
    localparam logic [2:0] P_NGT = 3'd6;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       ped_req = 1'b0;
    logic       night   = 1'b0;
    logic [2:0] ns_light, ew_light, phase;
    logic       ped_walk, ped_wait, tick_o;
    logic [3:0] remain_tens, remain_ones;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    intersection_ctrl #(
        .F_CLK(10), .F_TICK(1), .T_GREEN(3), .T_YELLOW(2), .T_ALLRED(1), .T_PED(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night(night),
        .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
        .ped_wait(ped_wait), .phase(phase), .remain_tens(remain_tens),
        .remain_ones(remain_ones), .tick_o(tick_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected {ns_light, ew_light} for a phase.
    function automatic logic [5:0] exp_lights(input logic [2:0] p, input logic b);
        case (p)
            P_NSG:   return 6'b001_100;
            P_NSY:   return 6'b010_100;
            P_EWG:   return 6'b100_001;
            P_EWY:   return 6'b100_010;
            P_NGT:   return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
            default: return 6'b100_100;
        endcase
    endfunction

    // Observe n negedge samples of one phase of dur ticks; optionally pulse
    // ped_req at sample req_at and drive night to night_val at sample night_at.
    task automatic run_phase(input string tag, input logic [2:0] p, input int dur, input int n,
                             input logic walk, input logic wait0, input int req_at,
                             input int night_at, input logic night_val);
        int         nbad;
        int         rem;
        logic       blk;
        logic       wexp;
        logic       texp;
        logic [5:0] lt;
        nbad = 0;
        check({tag, ".phase"}, 32'(phase), 32'(p));
        for (int i = 0; i < n; i++) begin
            blk  = (p == P_NGT) && (((i / 10) % 2) == 1);
            lt   = exp_lights(p, blk);
            rem  = (p == P_NGT) ? 0 : dur - i / 10;
            wexp = (req_at >= 0 && i > req_at && p != P_NGT) ? 1'b1 : wait0;
            texp = ((i % 10) == 9);
            if (phase !== p || {ns_light, ew_light} !== lt || ped_walk !== walk ||
                ped_wait !== wexp || tick_o !== texp) begin
                nbad++;
                if (nbad == 1)
                    $display("FAIL %s.sample%0d: got ph=%0d lt=%b walk=%b wait=%b tick=%b expected ph=%0d lt=%b walk=%b wait=%b tick=%b",
                             tag, i, phase, {ns_light, ew_light}, ped_walk, ped_wait, tick_o,
                             p, lt, walk, wexp, texp);
            end
            // BCD lags remain by one clk, so skip the first sample after each tick.
            if ((i % 10) != 0 && (remain_tens !== 4'(rem / 10) || remain_ones !== 4'(rem % 10)))
                nbad++;
            if (i == req_at)   ped_req = 1'b1;
            if (i == night_at) night   = night_val;
            @(negedge clk);
            ped_req = 1'b0;
        end
        check({tag, ".hold"}, 32'(nbad), 32'd0);
    endtask

    // Assert reset between edges, check reset values, release aligned to tick counter 0.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".phase"}, 32'(phase), 32'd5);
        check({tag, ".ns"},    32'(ns_light), 32'b100);
        check({tag, ".ew"},    32'(ew_light), 32'b100);
        check({tag, ".walk"},  32'(ped_walk), 32'd0);
        check({tag, ".wait"},  32'(ped_wait), 32'd0);
        check({tag, ".tick"},  32'(tick_o), 32'd0);
        check({tag, ".bcd"},   32'({remain_tens, remain_ones}), 32'h01);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_cycle(input string tag);
        run_phase({tag, ".arb0"}, P_ARB, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".nsg"},  P_NSG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".nsy"},  P_NSY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".ara"},  P_ARA, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".ewg"},  P_EWG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".ewy"},  P_EWY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase({tag, ".arb1"}, P_ARB, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
    endtask

    initial begin
        // Reset release with idle inputs: full day cycle.
        do_reset("rst0");
        idle_cycle("idle");

        // Request during NS_GREEN: walk granted in ALLRED_A.
        run_phase("ped.nsg", P_NSG, 3, 30, 1'b0, 1'b0, 5, -1, 1'b0);
        run_phase("ped.nsy", P_NSY, 2, 20, 1'b0, 1'b1, -1, -1, 1'b0);
        run_phase("ped.ara", P_ARA, 4, 40, 1'b1, 1'b0, -1, -1, 1'b0);
        run_phase("ped.ewg", P_EWG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ped.ewy", P_EWY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ped.arb", P_ARB, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);

        // Request on the ALLRED_A entry edge: served in ALLRED_B instead.
        run_phase("edge.nsg", P_NSG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("edge.nsy", P_NSY, 2, 20, 1'b0, 1'b0, 19, -1, 1'b0);
        run_phase("edge.ara", P_ARA, 1, 10, 1'b0, 1'b1, -1, -1, 1'b0);
        run_phase("edge.ewg", P_EWG, 3, 30, 1'b0, 1'b1, -1, -1, 1'b0);
        run_phase("edge.ewy", P_EWY, 2, 20, 1'b0, 1'b1, -1, -1, 1'b0);
        run_phase("edge.arb", P_ARB, 4, 40, 1'b1, 1'b0, -1, -1, 1'b0);

        // Night asserted in EW_GREEN: cycle completes, then flash; request ignored.
        run_phase("ngt.nsg",  P_NSG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.nsy",  P_NSY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.ara",  P_ARA, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.ewg",  P_EWG, 3, 30, 1'b0, 1'b0, -1, 5, 1'b1);
        run_phase("ngt.ewy",  P_EWY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.arb",  P_ARB, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.on",   P_NGT, 0, 40, 1'b0, 1'b0, 15, 35, 1'b0);
        run_phase("ngt.exit", P_ARB, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("ngt.nsg2", P_NSG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);

        // Reset mid-EW_YELLOW with a pending request, then a clean restart.
        run_phase("mid.nsy", P_NSY, 2, 20, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("mid.ara", P_ARA, 1, 10, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("mid.ewg", P_EWG, 3, 30, 1'b0, 1'b0, -1, -1, 1'b0);
        run_phase("mid.ewy", P_EWY, 2, 5,  1'b0, 1'b0, 1, -1, 1'b0);
        check("mid.pre_wait", 32'(ped_wait), 32'd1);
        do_reset("rst1");
        idle_cycle("again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
